// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : UART transmitter fed by a small TX FIFO. Frame format
//               (5-8 data bits, optional odd/even parity, 1 or 2 stop bits)
//               and baud divider are latched per frame when an entry is
//               popped. The serial output is registered.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [1:0]       data_bits_i,
  input  logic             stop_bits_i,
  input  logic             parity_bit_i,
  input  logic             parity_bit_mode_i,
  input  logic [DIV_W-1:0] baud_div_i,
  input  logic [7:0]       tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic [LVL_W-1:0] fifo_level_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [DIV_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_cnt;

  // Per-frame latched configuration
  logic [7:0]       r_data;
  logic [1:0]       r_dbits;
  logic             r_stop2;
  logic             r_par_en;
  logic             r_par_even;
  logic [DIV_W-1:0] r_div;

  logic             w_tick;
  logic             w_last_data;
  logic             w_last_stop;
  logic             w_parity;
  logic [7:0]       w_len_mask;
  logic             w_tx_nxt;
  logic             r_tx;

  assign w_full  = (r_count == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  // A write while full is dropped even when a pop frees a slot this cycle
  assign w_push  = tx_valid_i && !w_full;
  // Every transition into START consumes one FIFO entry
  assign w_pop   = (w_state_nxt == S_START) &&
                   ((r_state == S_IDLE) || (r_state == S_STOP));

  assign w_tick      = (r_baud_cnt == r_div);
  // Data length 5..8 maps to last bit index 4..7, i.e. {1, data_bits}
  assign w_last_data = (r_bit_cnt == {1'b1, r_dbits});
  assign w_last_stop = (r_bit_cnt == {2'b00, r_stop2});
  // r_data is already masked to the frame length, so a full XOR suffices
  assign w_parity    = (^r_data) ^ ~r_par_even;

  // Mask off bits above the selected data length before latching
  always_comb begin
    w_len_mask = 8'hFF;
    case (data_bits_i)
      2'd0:    w_len_mask = 8'h1F;
      2'd1:    w_len_mask = 8'h3F;
      2'd2:    w_len_mask = 8'h7F;
      default: w_len_mask = 8'hFF;
    endcase
  end

  // FIFO storage write port (contents need no reset; pointers qualify them)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data_i;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (en_i && !w_empty) w_state_nxt = S_START;
      S_START:  if (w_tick) w_state_nxt = S_DATA;
      S_DATA:   if (w_tick && w_last_data) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_tick && w_last_stop) begin
          w_state_nxt = (en_i && !w_empty) ? S_START : S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Frame latch on pop, baud and bit counters cleared on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_dbits    <= '0;
      r_stop2    <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_even <= 1'b0;
      r_div      <= '0;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_pop) begin
      r_data     <= r_mem[r_rd_ptr] & w_len_mask;
      r_dbits    <= data_bits_i;
      r_stop2    <= stop_bits_i;
      r_par_en   <= parity_bit_i;
      r_par_even <= parity_bit_mode_i;
      r_div      <= baud_div_i;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_state_nxt != r_state) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (r_state != S_IDLE) begin
      if (w_tick) begin
        r_baud_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + 1'b1;
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end
    end
  end

  // FSM output logic: line level for the current state
  always_comb begin
    w_tx_nxt = 1'b1;
    case (r_state)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = r_data[r_bit_cnt];
      S_PARITY: w_tx_nxt = w_parity;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // Registered serial line, forced idle-high on reset
  always_ff @(posedge clk) begin
    if (rst) r_tx <= 1'b1;
    else     r_tx <= w_tx_nxt;
  end

  assign tx_o         = r_tx;
  assign tx_ready_o   = !w_full;
  assign busy_o       = (r_state != S_IDLE) || !w_empty;
  assign fifo_level_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed plus randomized checks of uart_tx_fifo. Expected
//               line waveforms are built from the frame format rules
//               (start, LSB-first data, parity, stops, bit length div+1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int LIMIT = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  db;
  logic        sb;
  logic        pe;
  logic        pm;
  logic [15:0] div;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        tx;
  logic        busy;
  logic [3:0]  level;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_fifo dut (
    .clk               (clk),
    .rst               (rst),
    .en_i              (en),
    .data_bits_i       (db),
    .stop_bits_i       (sb),
    .parity_bit_i      (pe),
    .parity_bit_mode_i (pm),
    .baud_div_i        (div),
    .tx_data_i         (data),
    .tx_valid_i        (valid),
    .tx_ready_o        (ready),
    .tx_o              (tx),
    .busy_o            (busy),
    .fifo_level_o      (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; write lasts exactly one rising edge
  task automatic push(input logic [7:0] d, output logic acc);
    data  = d;
    valid = 1'b1;
    acc   = ready;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Wait for a start bit, then check every cycle of the expected frame.
  task automatic check_frame(input logic [7:0] d, input logic [1:0] fdb, input logic fsb,
                             input logic fpe, input logic fpm, input logic [15:0] fdiv,
                             input bit scramble, output int gap);
    logic exp_bits[$];
    logic par;
    logic seen;
    bit   mism;
    int   n;
    gap = 0;
    while (tx !== 1'b0 && gap < LIMIT) begin
      @(negedge clk);
      gap++;
    end
    chk("start_bit_seen", (gap < LIMIT), 1);
    if (gap >= LIMIT) return;
    chk("busy_in_frame", busy, 1);
    if (scramble) begin
      db  = 2'($urandom);
      sb  = 1'($urandom);
      pe  = 1'($urandom);
      pm  = 1'($urandom);
      div = 16'($urandom_range(0, 3));
    end
    n   = int'(fdb) + 5;
    par = 1'b0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      exp_bits.push_back(d[i]);
      par ^= d[i];
    end
    if (fpe) exp_bits.push_back(fpm ? par : ~par);
    exp_bits.push_back(1'b1);
    if (fsb) exp_bits.push_back(1'b1);
    for (int k = 0; k < exp_bits.size(); k++) begin
      mism = 0;
      seen = tx;
      for (int c = 0; c <= int'(fdiv); c++) begin
        if (!mism) begin
          seen = tx;
          if (tx !== exp_bits[k]) mism = 1;
        end
        @(negedge clk);
      end
      chk($sformatf("frame_%02h_bit%0d", d, k), seen, exp_bits[k]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic       acc;
    logic [7:0] bytes[$];
    logic [7:0] b;
    int         gap;
    bit         low_seen;

    rst = 1'b1; en = 1'b0; db = 2'd3; sb = 1'b0; pe = 1'b0; pm = 1'b0;
    div = 16'd3; data = 8'h00; valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_level", level, 0);
    chk("reset_ready", ready, 1);

    // 8N1, divider 3, 0xA5; write-to-start latency of two edges
    en = 1'b1;
    push(8'hA5, acc);
    check_frame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 16'd3, 0, gap);
    chk("a5_latency", gap, 2);
    chk("a5_busy_after", busy, 0);
    chk("a5_level_after", level, 0);

    // 7E2, divider 0, 0x83: bit 7 must not be sent
    db = 2'd2; sb = 1'b1; pe = 1'b1; pm = 1'b1; div = 16'd0;
    push(8'h83, acc);
    check_frame(8'h83, 2'd2, 1'b1, 1'b1, 1'b1, 16'd0, 0, gap);
    chk("83_latency", gap, 2);

    // 5O1 parity extremes
    db = 2'd0; sb = 1'b0; pe = 1'b1; pm = 1'b0; div = 16'd1;
    push(8'h1F, acc);
    check_frame(8'h1F, 2'd0, 1'b0, 1'b1, 1'b0, 16'd1, 0, gap);
    push(8'h00, acc);
    check_frame(8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 16'd1, 0, gap);

    // Fill while disabled, overflow write refused, then back-to-back drain
    db = 2'd3; sb = 1'b0; pe = 1'b0; div = 16'd1; en = 1'b0;
    bytes.delete();
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      push(b, acc);
      chk($sformatf("fill_ready_%0d", i), acc, (i < 8) ? 1 : 0);
      if (i < 8) bytes.push_back(b);
    end
    chk("full_level", level, 8);
    chk("full_ready", ready, 0);
    chk("disabled_tx_idle", tx, 1);
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_frame(bytes[i], 2'd3, 1'b0, 1'b0, 1'b0, 16'd1, 0, gap);
      chk($sformatf("drain_gap_%0d", i), gap, (i == 0) ? 2 : 0);
    end
    chk("drain_busy_after", busy, 0);

    // Write while full coinciding with a pop is dropped; next write lands
    en = 1'b0;
    bytes.delete();
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      push(b, acc);
      bytes.push_back(b);
    end
    data = 8'hEE; valid = 1'b1; en = 1'b1;
    @(negedge clk);
    chk("drop_level", level, 7);
    data = 8'h5A;
    @(negedge clk);
    valid = 1'b0;
    chk("refill_level", level, 8);
    bytes.push_back(8'h5A);
    for (int i = 0; i < 9; i++) begin
      check_frame(bytes[i], 2'd3, 1'b0, 1'b0, 1'b0, 16'd1, 0, gap);
      chk($sformatf("drop_gap_%0d", i), gap, 0);
    end

    // Configuration changed mid-frame only affects the following frame
    db = 2'd1; sb = 1'b1; pe = 1'b1; pm = 1'b1; div = 16'd2;
    push(8'hC6, acc);
    check_frame(8'hC6, 2'd1, 1'b1, 1'b1, 1'b1, 16'd2, 1, gap);
    chk("scramble_latency", gap, 2);

    // Randomized single frames
    for (int i = 0; i < 16; i++) begin
      logic [1:0]  rdb;
      logic        rsb, rpe, rpm;
      logic [15:0] rdiv;
      rdb = 2'($urandom); rsb = 1'($urandom); rpe = 1'($urandom); rpm = 1'($urandom);
      rdiv = 16'($urandom_range(0, 3));
      b = 8'($urandom);
      db = rdb; sb = rsb; pe = rpe; pm = rpm; div = rdiv;
      push(b, acc);
      check_frame(b, rdb, rsb, rpe, rpm, rdiv, ($urandom_range(0, 1) == 1), gap);
      chk($sformatf("rand_latency_%0d", i), gap, 2);
      chk($sformatf("rand_busy_after_%0d", i), busy, 0);
    end

    // Reset during data bit 3 with four entries still queued
    db = 2'd3; sb = 1'b0; pe = 1'b0; div = 16'd2; en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'($urandom), acc);
    en = 1'b1;
    gap = 0;
    while (tx !== 1'b0 && gap < LIMIT) begin
      @(negedge clk);
      gap++;
    end
    chk("rst_frame_started", (gap < LIMIT), 1);
    repeat (13) @(negedge clk);
    chk("rst_pre_level", level, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx", tx, 1);
    chk("midrst_level", level, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 1);
    low_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) low_seen = 1;
    end
    chk("midrst_no_frames", low_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
